// File: rtl/frame_buffer_ram_if.sv
// frame_buffer_ram_if: pixel write/read, clear request and status signals of the frame buffer.
interface frame_buffer_ram_if #(
    parameter int PIXEL_W = 8,
    parameter int XY_W    = 9
);
    logic               w_en;
    logic [XY_W-1:0]    w_x;
    logic [XY_W-1:0]    w_y;
    logic [PIXEL_W-1:0] w_data;
    logic               r_en;
    logic [XY_W-1:0]    r_x;
    logic [XY_W-1:0]    r_y;
    logic [PIXEL_W-1:0] r_data;
    logic               r_valid;
    logic               clr_req;
    logic [PIXEL_W-1:0] clr_color;
    logic               busy;
    logic               clr_done;
    logic               w_drop;

    modport master (
        output w_en, w_x, w_y, w_data, r_en, r_x, r_y, clr_req, clr_color,
        input  r_data, r_valid, busy, clr_done, w_drop
    );

    modport slave (
        input  w_en, w_x, w_y, w_data, r_en, r_x, r_y, clr_req, clr_color,
        output r_data, r_valid, busy, clr_done, w_drop
    );
endinterface

// File: rtl/frame_buffer_ram.sv
// frame_buffer_ram: XY-addressed block-RAM frame buffer with a one-word-per-cycle full-frame clear.
// Define FB_BYPASS_EN to forward same-cycle write data to a read of the same address.
module frame_buffer_ram #(
    parameter int PIXEL_W  = 8,
    parameter int SCREEN_W = 270,
    parameter int SCREEN_H = 270,
    parameter int ADDR_W   = 17,
    parameter int XY_W     = 9
) (
    input  logic             clk,
    input  logic             reset,
    frame_buffer_ram_if.slave bus
);
    localparam int DEPTH = SCREEN_W * SCREEN_H;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  clr_addr, w_addr, r_addr, ram_addr;
    logic [PIXEL_W-1:0] clr_col, ram_din, r_word;
    logic               w_in, r_in, ext_we, ram_we, clearing;

    (* ramstyle = "M9K" *) logic [PIXEL_W-1:0] mem [DEPTH];

    assign w_in   = 32'(bus.w_x) < SCREEN_W && 32'(bus.w_y) < SCREEN_H;
    assign r_in   = 32'(bus.r_x) < SCREEN_W && 32'(bus.r_y) < SCREEN_H;
    assign w_addr = ADDR_W'(bus.w_y) * ADDR_W'(SCREEN_W) + ADDR_W'(bus.w_x);
    assign r_addr = ADDR_W'(bus.r_y) * ADDR_W'(SCREEN_W) + ADDR_W'(bus.r_x);

    assign clearing = state == CLEAR;
    assign ext_we   = bus.w_en && w_in && !clearing;
    assign ram_we   = clearing || ext_we;
    assign ram_addr = clearing ? clr_addr : w_addr;
    assign ram_din  = clearing ? clr_col : bus.w_data;

    always_comb begin
        state_nx     = state == IDLE  ? (bus.clr_req ? CLEAR : IDLE) :
                       state == CLEAR ? (clr_addr == ADDR_W'(DEPTH - 1) ? DONE : CLEAR) : IDLE;
        bus.busy     = clearing;
        bus.clr_done = state == DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clr_addr   <= '0;
            clr_col    <= '0;
            bus.w_drop <= 1'b0;
        end else begin
            state      <= state_nx;
            clr_addr   <= clearing ? clr_addr + 1'b1 : '0;
            if (state == IDLE && bus.clr_req)
                clr_col <= bus.clr_color;
            bus.w_drop <= bus.w_en && (!w_in || clearing);
        end
    end

    // The array carries no reset; the write is gated so reset never disturbs it.
    always_ff @(posedge clk) begin
        if (ram_we && !reset)
            mem[ram_addr] <= ram_din;
    end

`ifdef FB_BYPASS_EN
    assign r_word = ram_we && ram_addr == r_addr ? ram_din : mem[r_addr];
`else
    assign r_word = mem[r_addr];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.r_data  <= '0;
            bus.r_valid <= 1'b0;
        end else begin
            bus.r_valid <= bus.r_en;
            if (bus.r_en)
                bus.r_data <= r_in ? r_word : '0;
        end
    end
endmodule

// File: tb/tb_frame_buffer_ram.sv
// tb_frame_buffer_ram: directed checks of writes, reads, drops, bypass, clear and reset abort.
module tb_frame_buffer_ram;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;

    frame_buffer_ram_if #(.PIXEL_W(8), .XY_W(9)) fb ();

    frame_buffer_ram dut (.clk(clk), .reset(reset), .bus(fb));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int x, input int y, input logic [7:0] d);
        fb.w_en = 1'b1; fb.w_x = 9'(x); fb.w_y = 9'(y); fb.w_data = d;
        tick();
        fb.w_en = 1'b0;
    endtask

    task automatic rd(input int x, input int y);
        fb.r_en = 1'b1; fb.r_x = 9'(x); fb.r_y = 9'(y);
        tick();
        fb.r_en = 1'b0;
    endtask

    int         tx [4] = '{269, 1, 0, 100};
    int         ty [4] = '{269, 0, 1, 200};
    logic [7:0] td [4] = '{8'hC3, 8'h12, 8'h34, 8'h9E};

    initial begin
        int  cnt;
        logic done_seen;
        reset = 1'b1;
        fb.w_en = 0; fb.w_x = 0; fb.w_y = 0; fb.w_data = 0;
        fb.r_en = 0; fb.r_x = 0; fb.r_y = 0;
        fb.clr_req = 0; fb.clr_color = 0;
        repeat (2) tick();
        chk("rst_r_data", fb.r_data, 0);
        chk("rst_r_valid", fb.r_valid, 0);
        chk("rst_busy", fb.busy, 0);
        chk("rst_clr_done", fb.clr_done, 0);
        chk("rst_w_drop", fb.w_drop, 0);
        reset = 1'b0;
        tick();

        wr(5, 3, 8'hA5);
        chk("wr_no_drop", fb.w_drop, 0);
        rd(5, 3);
        chk("rd_valid", fb.r_valid, 1);
        chk("rd_data", fb.r_data, 8'hA5);
        tick();
        chk("rd_valid_idle", fb.r_valid, 0);
        chk("rd_hold", fb.r_data, 8'hA5);

        for (int i = 0; i < 4; i++) wr(tx[i], ty[i], td[i]);
        for (int i = 0; i < 4; i++) begin
            rd(tx[i], ty[i]);
            chk($sformatf("tbl_rd%0d", i), fb.r_data, td[i]);
        end

        wr(0, 0, 8'h22);
        wr(270, 0, 8'h11);
        chk("oor_drop", fb.w_drop, 1);
        tick();
        chk("oor_drop_pulse", fb.w_drop, 0);
        rd(0, 0);
        chk("oor_addr0_kept", fb.r_data, 8'h22);
        rd(0, 270);
        chk("oor_rd_data", fb.r_data, 0);
        chk("oor_rd_valid", fb.r_valid, 1);

        wr(7, 7, 8'h00);
        fb.w_en = 1; fb.w_x = 7; fb.w_y = 7; fb.w_data = 8'h5A;
        fb.r_en = 1; fb.r_x = 7; fb.r_y = 7;
        tick();
        fb.w_en = 0; fb.r_en = 0;
`ifdef FB_BYPASS_EN
        chk("same_cycle_rw", fb.r_data, 8'h5A);
`else
        chk("same_cycle_rw", fb.r_data, 8'h00);
`endif
        rd(7, 7);
        chk("after_rw", fb.r_data, 8'h5A);

        // Clear aborted by reset after 100 cycles.
        fb.clr_req = 1; fb.clr_color = 8'h55;
        tick();
        fb.clr_req = 0;
        chk("abort_busy_rise", fb.busy, 1);
        fb.r_en = 1; fb.r_x = 0; fb.r_y = 0;
        repeat (99) tick();
        reset = 1'b1;
        #1;
        chk("abort_busy", fb.busy, 0);
        chk("abort_r_valid", fb.r_valid, 0);
        chk("abort_r_data", fb.r_data, 0);
        chk("abort_clr_done", fb.clr_done, 0);
        fb.r_en = 0;
        tick();
        reset = 1'b0;
        done_seen = 0;
        repeat (5) begin
            tick();
            done_seen |= fb.clr_done | fb.busy;
        end
        chk("abort_no_done", done_seen, 0);

        // Full clear, started together with a write to (0,0).
        fb.w_en = 1; fb.w_x = 0; fb.w_y = 0; fb.w_data = 8'hFF;
        fb.clr_req = 1; fb.clr_color = 8'h3C;
        tick();
        fb.w_en = 0; fb.clr_req = 0; fb.clr_color = 8'h99;
        chk("clr_busy_rise", fb.busy, 1);
        cnt = 0;
        while (fb.busy && cnt < 80000) begin
            cnt++;
            if (cnt == 50) begin
                fb.w_en = 1; fb.w_x = 10; fb.w_y = 10; fb.w_data = 8'h77;
            end
            if (cnt == 51) begin
                fb.w_en = 0;
                chk("busy_drop", fb.w_drop, 1);
            end
            if (cnt == 52) chk("busy_drop_pulse", fb.w_drop, 0);
            if (cnt == 60) begin
                fb.r_en = 1; fb.r_x = 0; fb.r_y = 0;
            end
            if (cnt == 61) begin
                fb.r_en = 0;
                chk("clr_rd_valid", fb.r_valid, 1);
                chk("clr_rd_data", fb.r_data, 8'h3C);
            end
            fb.clr_req = cnt == 70;
            tick();
        end
        chk("clr_cycles", cnt, 72900);
        chk("clr_done_pulse", fb.clr_done, 1);
        fb.clr_req = 1;
        tick();
        fb.clr_req = 0;
        chk("clr_done_end", fb.clr_done, 0);
        chk("done_req_ignored", fb.busy, 0);
        tick();
        chk("idle_after_done", fb.busy, 0);
        rd(269, 269);
        chk("clr_last_pixel", fb.r_data, 8'h3C);
        rd(0, 0);
        chk("clr_over_write", fb.r_data, 8'h3C);
        rd(10, 10);
        chk("busy_write_lost", fb.r_data, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_buffer_ram.md
FRAME_BUFFER_RAM -- requirements
Module: frame_buffer_ram

Interface
REQ-001 The block SHALL have these parameters:
- PIXEL_W, default 8, bits per pixel.
- SCREEN_W, default 270, pixels per row.
- SCREEN_H, default 270, rows per frame.
- ADDR_W, default 17, linear address width; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H.
- XY_W, default 9, width of the x and y coordinates.

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high.
- w_en  in  1  pixel write request.
- w_x, w_y  in  XY_W  write coordinates.
- w_data  in  PIXEL_W  write pixel.
- r_en  in  1  pixel read request.
- r_x, r_y  in  XY_W  read coordinates.
- r_data  out  PIXEL_W  read pixel, registered.
- r_valid  out  1  r_data is valid this cycle.
- clr_req  in  1  start a full-frame clear.
- clr_color  in  PIXEL_W  fill value, sampled when clr_req is accepted.
- busy  out  1  a clear is in progress.
- clr_done  out  1  one-cycle pulse when a clear completes.
- w_drop  out  1  one-cycle pulse when a write is discarded.

Function
REQ-003 Storage SHALL be SCREEN_W*SCREEN_H words of PIXEL_W bits, inferred as block RAM with ramstyle "M9K" and no reset on the array.
REQ-004 The linear address SHALL be y*SCREEN_W+x, computed at ADDR_W bits with no truncation for in-range coordinates.
REQ-005 A coordinate pair SHALL be in range iff x<SCREEN_W and y<SCREEN_H.
REQ-006 An in-range write with w_en=1 while busy=0 SHALL update memory at that rising edge.
REQ-007 A write SHALL be discarded, with w_drop=1 on the next cycle, when w_en=1 and either the coordinates are out of range or busy=1.
REQ-008 Read latency SHALL be exactly 1 cycle: r_en sampled at edge N gives r_valid=1 and r_data after edge N; r_valid=0 in every cycle following r_en=0.
REQ-009 An out-of-range read SHALL return r_data=0 with r_valid=1.
REQ-010 Reads SHALL be serviced during a clear and return the current memory contents, which may be partially cleared.
REQ-011 When r_en=0, r_data SHALL hold its previous value.
REQ-012 The clear FSM SHALL have three states:
- IDLE: busy=0.
- CLEAR: busy=1; writes clr_color to one address per cycle, ascending from 0 to SCREEN_W*SCREEN_H-1.
- DONE: exactly one cycle, clr_done=1, busy=0, then returns to IDLE.
REQ-013 A clear of D words SHALL take D cycles in CLEAR; busy SHALL rise the cycle after clr_req is accepted.
REQ-014 clr_req SHALL be accepted only in IDLE; clr_req in CLEAR or DONE SHALL be ignored, not queued.
REQ-015 If w_en and clr_req are both asserted in IDLE, the external write SHALL complete that cycle and the clear SHALL start on the next cycle, overwriting it.
REQ-016 A read and a write to the same address in the same cycle SHALL return the old data, unless FB_BYPASS_EN is defined (see REQ-020).

Reset
REQ-017 Asserting reset SHALL immediately force the FSM to IDLE and set r_data=0, r_valid=0, busy=0, clr_done=0 and w_drop=0.
REQ-018 Reset asserted mid-clear SHALL abort the clear without producing clr_done; memory contents are then undefined, and no RAM write occurs while reset is asserted.
REQ-019 Memory contents SHALL NOT be initialised by reset.

Configuration
REQ-020 With macro FB_BYPASS_EN defined, a same-cycle read and write to the same in-range address SHALL return the newly written data (external write or clear write) on r_data; without the macro, the old data SHALL be returned and no bypass logic SHALL be synthesised.

Verification
REQ-021 Write (5,3)=0xA5, then read (5,3) the next cycle -> r_valid=1 and r_data=0xA5 exactly one cycle after r_en.
REQ-022 Write (270,0)=0x11 -> w_drop pulses for one cycle; a subsequent read of address 0 is unchanged; a read of (0,270) -> r_data=0x00, r_valid=1.
REQ-023 clr_req with clr_color=0x3C, defaults -> busy=1 for 72900 cycles, then a single clr_done pulse; a read of (269,269) -> 0x3C; a w_en during busy -> w_drop=1 and the write is not applied.
REQ-024 Assert reset at clear cycle 100 -> busy=0 and r_valid=0 immediately; no clr_done follows; a new clr_req is accepted after reset deasserts.
REQ-025 Write (7,7)=0x5A and read (7,7) in the same cycle, with old value 0x00 -> r_data=0x00 without FB_BYPASS_EN, 0x5A with it.
REQ-026 Simultaneous w_en (0,0)=0xFF and clr_req with clr_color=0x01 in IDLE -> after clr_done, a read of (0,0) gives 0x01.
